uart_key_msg_sched: RTL and testbench

//  Shares one byte-level UART transmitter between 4 key requesters on the home-assist board.

---
 rtl/uart_key_msg_sched_pkg.sv | 29 ++
 rtl/uart_key_msg_sched_rr_arb4.sv | 25 ++
 rtl/uart_key_msg_sched.sv | 140 ++++++++++++++
 tb/tb_uart_key_msg_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_key_msg_sched_pkg.sv
// rtl/uart_key_msg_sched_pkg.sv - frame constants, FSM states and byte builder for the key message scheduler
package uart_key_msg_sched_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hAA;
    localparam logic [1:0] LAST_IDX    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP
    } state_t;

    // Frame is HDR, key id (1..4), then HDR xor id as the check byte.
    function automatic logic [7:0] frame_byte(input logic [7:0] hdr,
                                              input logic [1:0] idx,
                                              input logic [1:0] g);
        logic [7:0] id;
        id = {6'b0, g} + 8'd1;
        case (idx)
            2'd0:    frame_byte = hdr;
            2'd1:    frame_byte = id;
            default: frame_byte = hdr ^ id;
        endcase
    endfunction

endpackage

// File: rtl/uart_key_msg_sched_rr_arb4.sv
// rtl/uart_key_msg_sched_rr_arb4.sv - combinational 4-way round-robin pick starting at ptr
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_vld,
    output logic [1:0] gnt_idx
);

    logic [1:0] cand;

    // Scan offsets high to low so the lowest offset from ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_key_msg_sched.sv
// rtl/uart_key_msg_sched.sv - shares one byte UART transmitter among 4 keys, sending HDR/ID/CHK frames
module uart_key_msg_sched
    import uart_key_msg_sched_pkg::*;
#(
    parameter int          N_KEY   = 4,
    parameter logic [7:0]  HDR     = HDR_DEFAULT,
    parameter logic [15:0] GAP_CYC = 16'd500,
    parameter logic [15:0] ACK_TO  = 16'd1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_KEY-1:0] in_key_en,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             over_rx,
    output logic             frame_err,
    output logic [N_KEY-1:0] pend,
    output logic [1:0]       grant_id
);

    state_t           state, state_n;
    logic [N_KEY-1:0] key_q;
    logic [N_KEY-1:0] rise;
    logic [N_KEY-1:0] clr_mask;
    logic [1:0]       rr_ptr;
    logic [1:0]       idx;
    logic [15:0]      cnt;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;

    logic do_grant, do_load, do_start, next_byte;
    logic clr_cnt, inc_cnt, fin_ok, fin_err;

    rr_arb4 u_arb (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign rise     = in_key_en & ~key_q;
    assign clr_mask = do_grant ? (N_KEY'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        do_grant  = 1'b0;
        do_load   = 1'b0;
        do_start  = 1'b0;
        next_byte = 1'b0;
        clr_cnt   = 1'b0;
        inc_cnt   = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    do_grant = 1'b1;
                    state_n  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                do_load = 1'b1;
                state_n = ST_START;
            end
            ST_START: begin
                if (!tx_busy) begin
                    do_start = 1'b1;
                    clr_cnt  = 1'b1;
                    state_n  = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_n = ST_WAIT_LO;
                end else if (cnt >= ACK_TO - 16'd1) begin
                    fin_err = 1'b1;
                    clr_cnt = 1'b1;
                    state_n = ST_GAP;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx != LAST_IDX) begin
                        next_byte = 1'b1;
                        state_n   = ST_LOAD;
                    end else begin
                        fin_ok  = 1'b1;
                        clr_cnt = 1'b1;
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt >= GAP_CYC - 16'd1) state_n = ST_IDLE;
                else                        inc_cnt = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // A new edge on the granted key in the grant cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            pend      <= '0;
            rr_ptr    <= 2'd0;
            grant_id  <= 2'd0;
            idx       <= 2'd0;
            tx_data   <= 8'd0;
            tx_start  <= 1'b0;
            over_rx   <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= 16'd0;
        end else begin
            key_q     <= in_key_en;
            pend      <= (pend & ~clr_mask) | rise;
            tx_start  <= do_start;
            over_rx   <= fin_ok;
            frame_err <= fin_err;
            if (do_grant) begin
                grant_id <= gnt_idx;
                rr_ptr   <= gnt_idx + 2'd1;
                idx      <= 2'd0;
            end
            if (next_byte) idx <= idx + 2'd1;
            if (do_load) tx_data <= frame_byte(HDR, idx, grant_id);
            if (clr_cnt)                          cnt <= 16'd0;
            else if (inc_cnt && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_key_msg_sched.sv
// tb/tb_uart_key_msg_sched.sv - directed table-driven bench for uart_key_msg_sched with a byte-core model
module tb_uart_key_msg_sched;

    localparam int GAP_CYC  = 500;
    localparam int ACK_TO   = 1000;
    localparam int BYTE_CYC = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_key_en = 4'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       over_rx;
    logic       frame_err;
    logic [3:0] pend;
    logic [1:0] grant_id;

    uart_key_msg_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_key_en (in_key_en),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .over_rx   (over_rx),
        .frame_err (frame_err),
        .pend      (pend),
        .grant_id  (grant_id)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte core model: busy rises the clock after tx_start and lasts BYTE_CYC clocks.
    logic ack_en = 1'b1;
    int   busy_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start && !tx_busy && ack_en) begin
            tx_busy  <= 1'b1;
            busy_cnt <= BYTE_CYC;
        end else if (tx_busy) begin
            if (busy_cnt == 1) tx_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] bytes[$];
    int   n_over, n_err, n_start, last_evt, last_start, gap_meas, err_lat;
    logic after_evt = 1'b0;
    logic holding = 1'b0;
    logic [7:0] held;

    always @(negedge clk) begin
        if (!rst_n) begin
            holding   = 1'b0;
            after_evt = 1'b0;
        end else begin
            if (tx_start) begin
                check("start_while_busy", 64'(tx_busy), 64'd0);
                bytes.push_back(tx_data);
                held       = tx_data;
                holding    = 1'b1;
                n_start++;
                last_start = cyc;
                if (after_evt) begin
                    gap_meas  = cyc - last_evt;
                    after_evt = 1'b0;
                end
            end else if (holding && tx_busy) begin
                check("data_hold", 64'(tx_data), 64'(held));
            end
            if (over_rx) begin
                n_over++;
                last_evt  = cyc;
                after_evt = 1'b1;
            end
            if (frame_err) begin
                n_err++;
                err_lat   = cyc - last_start;
                last_evt  = cyc;
                after_evt = 1'b1;
            end
        end
    end

    task automatic clear_mon();
        bytes.delete();
        n_over    = 0;
        n_err     = 0;
        n_start   = 0;
        gap_meas  = -1;
        err_lat   = -1;
        after_evt = 1'b0;
    endtask

    task automatic check_bytes(input string name, input logic [95:0] exp, input int n);
        check({name, "_count"}, 64'(bytes.size()), 64'(n));
        for (int i = 0; i < n && i < bytes.size(); i++)
            check(name, 64'(bytes[i]), 64'(exp[8*(n-1-i) +: 8]));
    endtask

    task automatic wait_start(input int target, input int budget, input string name);
        int k = 0;
        while (n_start < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(n_start >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"},  64'(tx_start),  64'd0);
        check({tag, "_tx_data"},   64'(tx_data),   64'd0);
        check({tag, "_over_rx"},   64'(over_rx),   64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_pend"},      64'(pend),      64'd0);
        check({tag, "_grant_id"},  64'(grant_id),  64'd0);
    endtask

    typedef struct {
        logic [3:0]  keys;
        int          nfr;
        logic [47:0] exp;
        logic [1:0]  gid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'b0100, 1, 48'hAA03A9,        2'd2};
        vecs[1] = '{4'b1000, 1, 48'hAA04AE,        2'd3};
        vecs[2] = '{4'b1001, 2, 48'hAA01AB_AA04AE, 2'd3};
        vecs[3] = '{4'b1010, 2, 48'hAA02A8_AA04AE, 2'd3};
        vecs[4] = '{4'b0110, 2, 48'hAA02A8_AA03A9, 2'd2};
        vecs[5] = '{4'b0011, 2, 48'hAA01AB_AA02A8, 2'd1};

        clear_mon();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            in_key_en = vecs[v].keys;
            repeat (2000) @(negedge clk);
            in_key_en = 4'b0;
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_over", v), 64'(n_over), 64'(vecs[v].nfr));
            check($sformatf("v%0d_err", v), 64'(n_err), 64'd0);
            check_bytes($sformatf("v%0d_bytes", v), 96'(vecs[v].exp), 3 * vecs[v].nfr);
            check($sformatf("v%0d_grant_id", v), 64'(grant_id), 64'(vecs[v].gid));
            check($sformatf("v%0d_pend", v), 64'(pend), 64'd0);
            if (vecs[v].nfr == 2)
                check($sformatf("v%0d_gap", v), 64'(gap_meas), 64'(GAP_CYC + 3));
        end

        // Repeated presses of one key during a frame merge into one request.
        clear_mon();
        in_key_en = 4'b0001;
        wait_start(1, 100, "merge_first_start");
        for (int p = 0; p < 3; p++) begin
            in_key_en[1] = 1'b1;
            repeat (3) @(negedge clk);
            in_key_en[1] = 1'b0;
            repeat (3) @(negedge clk);
        end
        in_key_en = 4'b0;
        repeat (1500) @(negedge clk);
        check("merge_over", 64'(n_over), 64'd2);
        check_bytes("merge_bytes", 96'h000000_000000_AA01AB_AA02A8, 6);
        check("merge_grant_id", 64'(grant_id), 64'd1);

        // Ack timeout: first byte never acknowledged.
        clear_mon();
        ack_en = 1'b0;
        in_key_en = 4'b1000;
        begin
            int k = 0;
            while (n_err == 0 && k < 1300) begin
                @(negedge clk);
                k++;
            end
        end
        check("to_err_seen", 64'(n_err), 64'd1);
        check("to_no_over", 64'(n_over), 64'd0);
        ack_en = 1'b1;
        in_key_en = 4'b0100;
        repeat (1000) @(negedge clk);
        in_key_en = 4'b0;
        check("to_latency", 64'(err_lat), 64'(ACK_TO));
        check("to_err_count", 64'(n_err), 64'd1);
        check("to_gap", 64'(gap_meas), 64'(GAP_CYC + 3));
        check("to_over", 64'(n_over), 64'd1);
        check_bytes("to_bytes", 96'hAA_AA03A9, 4);
        check("to_grant_id", 64'(grant_id), 64'd2);

        // Reset while the second byte is shifting.
        clear_mon();
        in_key_en = 4'b0010;
        repeat (3) @(negedge clk);
        in_key_en = 4'b0;
        wait_start(2, 300, "rst_second_start");
        repeat (5) @(negedge clk);
        check("rst_busy_before", 64'(tx_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (200) @(negedge clk);
        check("rst_no_start", 64'(n_start), 64'd0);
        in_key_en = 4'b0100;
        repeat (700) @(negedge clk);
        in_key_en = 4'b0;
        check("rst_over", 64'(n_over), 64'd1);
        check_bytes("rst_bytes", 96'hAA03A9, 3);
        check("rst_grant_id", 64'(grant_id), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
